// File: rtl/serial_packet_rx.sv
// Receives 11-bit serial frames (start, 8 data LSB first, odd parity, stop) from an
// asynchronous device clock and assembles WORDS bytes into one packet.
module serial_packet_rx #(
  parameter int WORDS       = 3,
  parameter int BIT_TIMEOUT = 2000,
  parameter int PKT_TIMEOUT = 20000
) (
  input  logic                 ck,
  input  logic                 reset,
  input  logic                 clock,
  input  logic                 currentBit,
  output logic                 packet_valid,
  output logic [8*WORDS-1:0]   packet_data,
  output logic                 err_valid,
  output logic [1:0]           err_code
);

  localparam int MAXT = (BIT_TIMEOUT > PKT_TIMEOUT) ? BIT_TIMEOUT : PKT_TIMEOUT;
  localparam int TW   = $clog2(MAXT) + 1;
  localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam logic [TW-1:0] T_MAX    = TW'(MAXT);
  localparam logic [TW-1:0] BIT_LIM  = TW'(BIT_TIMEOUT - 1);
  localparam logic [TW-1:0] PKT_LIM  = TW'(PKT_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  logic [1:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         dat_sync_q, dat_sync_d;
  logic               clk_prev_q, clk_prev_d;
  logic [1:0]         state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [8*WORDS-1:0] buf_q, buf_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [8*WORDS-1:0] packet_data_q, packet_data_d;
  logic               packet_valid_q, packet_valid_d;
  logic               err_valid_q, err_valid_d;
  logic [1:0]         err_code_q, err_code_d;

  logic fall, bit_in;

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  always_comb begin
    clk_sync_d     = {clk_sync_q[0], clock};
    dat_sync_d     = {dat_sync_q[0], currentBit};
    clk_prev_d     = clk_sync_q[1];
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_d          = par_q;
    idx_d          = idx_q;
    buf_d          = buf_q;
    packet_data_d  = packet_data_q;
    packet_valid_d = 1'b0;
    err_valid_d    = 1'b0;
    err_code_d     = err_code_q;
    tmo_d          = (tmo_q == T_MAX) ? tmo_q : tmo_q + 1'b1;

    if (fall) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: if (!bit_in) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
        S_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PAR;
        end
        S_PAR: begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          // A bad stop bit outranks a parity failure.
          if (!bit_in) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b10;
            idx_d       = '0;
          end else if (!(^{shift_q, par_q})) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b01;
            idx_d       = '0;
          end else begin
            buf_d[(WORDS - 1 - int'(idx_q)) * 8 +: 8] = shift_q;
            if (idx_q == LAST_IDX) begin
              packet_data_d  = buf_d;
              packet_valid_d = 1'b1;
              idx_d          = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      endcase
    end else if (state_q != S_IDLE && tmo_q >= BIT_LIM) begin
      err_valid_d = 1'b1;
      err_code_d  = 2'b11;
      state_d     = S_IDLE;
      idx_d       = '0;
    end else if (state_q == S_IDLE && idx_q != '0 && tmo_q >= PKT_LIM) begin
      // Leaving idx at 0 also stops this from firing again.
      err_valid_d = 1'b1;
      err_code_d  = 2'b11;
      idx_d       = '0;
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      clk_sync_q     <= 2'b11;
      dat_sync_q     <= 2'b11;
      clk_prev_q     <= 1'b1;
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      idx_q          <= '0;
      buf_q          <= '0;
      tmo_q          <= '0;
      packet_data_q  <= '0;
      packet_valid_q <= 1'b0;
      err_valid_q    <= 1'b0;
      err_code_q     <= 2'b00;
    end else begin
      clk_sync_q     <= clk_sync_d;
      dat_sync_q     <= dat_sync_d;
      clk_prev_q     <= clk_prev_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      idx_q          <= idx_d;
      buf_q          <= buf_d;
      tmo_q          <= tmo_d;
      packet_data_q  <= packet_data_d;
      packet_valid_q <= packet_valid_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
    end
  end

  assign packet_valid = packet_valid_q;
  assign packet_data  = packet_data_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_serial_packet_rx.sv
// Bench for serial_packet_rx: frame table, timeout/reset sequences, random frames vs. a byte-list model.
module tb_serial_packet_rx;
  localparam int WORDS  = 3;
  localparam int BIT_TO = 64;
  localparam int PKT_TO = 400;
  localparam int HALF   = 8;

  logic        ck = 1'b0;
  logic        reset = 1'b1;
  logic        clock = 1'b1;
  logic        currentBit = 1'b1;
  logic        packet_valid, err_valid;
  logic [23:0] packet_data;
  logic [1:0]  err_code;

  serial_packet_rx #(.WORDS(WORDS), .BIT_TIMEOUT(BIT_TO), .PKT_TIMEOUT(PKT_TO)) dut (
    .ck(ck), .reset(reset), .clock(clock), .currentBit(currentBit),
    .packet_valid(packet_valid), .packet_data(packet_data),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [1:0]  kind;   // 1 packet, 2 error
    logic [23:0] data;
    logic [1:0]  code;
  } ev_t;

  typedef struct {
    logic [7:0]  d;
    logic        p;
    logic        s;
    logic [1:0]  kind;   // 0 nothing expected
    logic [23:0] data;
    logic [1:0]  code;
  } vec_t;

  ev_t         ev_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_both = 0;
  int          n_spur = 0;
  logic [23:0] prev_data = '0;

  always @(negedge ck) begin
    if (packet_valid && err_valid) n_both <= n_both + 1;
    if (!reset && !packet_valid && packet_data !== prev_data) n_spur <= n_spur + 1;
    prev_data <= packet_data;
    if (packet_valid) ev_q.push_back({2'd1, packet_data, 2'd0});
    if (err_valid)    ev_q.push_back({2'd2, 24'd0, err_code});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic send_bit(input logic b);
    currentBit = b;
    cyc(HALF);
    clock = 1'b0;
    cyc(HALF);
    clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    cyc(12);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_one(input string nm, input logic [1:0] kind,
                           input logic [23:0] data, input logic [1:0] code);
    ev_t e;
    @(posedge ck);
    e = {kind, data, code};
    if (kind == 2'd0) begin
      chk({nm, " no_event"}, 64'(ev_q.size()), 64'd0);
    end else begin
      chk({nm, " count"}, 64'(ev_q.size()), 64'd1);
      if (ev_q.size() > 0) chk({nm, " event"}, 64'(ev_q[0]), 64'(e));
    end
    ev_q.delete();
  endtask

  vec_t        vecs[15];
  ev_t         exp_q[$];
  logic [7:0]  acc[$];

  initial begin
    vecs[0]  = '{8'h08, 1'b0, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[1]  = '{8'h12, 1'b1, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[2]  = '{8'hFF, 1'b1, 1'b1, 2'd1, 24'h0812FF, 2'd0};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 2'd2, 24'h0,      2'b01};
    vecs[4]  = '{8'h01, 1'b0, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[5]  = '{8'h02, 1'b0, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[6]  = '{8'h03, 1'b1, 1'b1, 2'd1, 24'h010203, 2'd0};
    vecs[7]  = '{8'h55, 1'b1, 1'b0, 2'd2, 24'h0,      2'b10};
    vecs[8]  = '{8'h44, 1'b1, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[9]  = '{8'h00, 1'b0, 1'b0, 2'd2, 24'h0,      2'b10};
    vecs[10] = '{8'h11, 1'b1, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[11] = '{8'h22, 1'b1, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[12] = '{8'h33, 1'b1, 1'b1, 2'd1, 24'h112233, 2'd0};
    vecs[13] = '{8'h7E, 1'b1, 1'b1, 2'd0, 24'h0,      2'd0};
    vecs[14] = '{8'h80, 1'b1, 1'b1, 2'd2, 24'h0,      2'b01};

    // Reset state
    cyc(3);
    chk("rst packet_valid", 64'(packet_valid), 64'd0);
    chk("rst err_valid",    64'(err_valid),    64'd0);
    chk("rst err_code",     64'(err_code),     64'd0);
    chk("rst packet_data",  64'(packet_data),  64'd0);
    reset = 1'b0;
    cyc(5);
    chk("post-rst err_valid", 64'(err_valid), 64'd0);
    ev_q.delete();

    for (int i = 0; i < 15; i++) begin
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s);
      check_one($sformatf("vec%0d", i), vecs[i].kind, vecs[i].data, vecs[i].code);
    end

    // Serial clock stalls mid-frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(BIT_TO + 40);
    check_one("bit_timeout", 2'd2, 24'h0, 2'b11);
    chk("bit_timeout data_held", 64'(packet_data), 64'h112233);

    // Gap between frames of one packet
    send_frame(8'h10, 1'b0, 1'b1);
    send_frame(8'h20, 1'b0, 1'b1);
    check_one("pkt_pre", 2'd0, 24'h0, 2'd0);
    cyc(PKT_TO + 40);
    check_one("pkt_timeout", 2'd2, 24'h0, 2'b11);
    send_frame(8'hAA, 1'b1, 1'b1);
    check_one("after_pto AA", 2'd0, 24'h0, 2'd0);
    send_frame(8'hBB, 1'b1, 1'b1);
    check_one("after_pto BB", 2'd0, 24'h0, 2'd0);
    send_frame(8'hCC, 1'b1, 1'b1);
    check_one("after_pto CC", 2'd1, 24'hAABBCC, 2'd0);

    // Reset during the second frame of a packet
    send_frame(8'h01, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    #1;
    chk("midrst packet_valid", 64'(packet_valid), 64'd0);
    chk("midrst err_valid",    64'(err_valid),    64'd0);
    chk("midrst err_code",     64'(err_code),     64'd0);
    chk("midrst packet_data",  64'(packet_data),  64'd0);
    cyc(3);
    reset = 1'b0;
    cyc(3);
    ev_q.delete();
    send_frame(8'h0A, 1'b1, 1'b1);
    check_one("post_rst 0A", 2'd0, 24'h0, 2'd0);
    send_frame(8'h0B, 1'b0, 1'b1);
    check_one("post_rst 0B", 2'd0, 24'h0, 2'd0);
    send_frame(8'h0C, 1'b1, 1'b1);
    check_one("post_rst 0C", 2'd1, 24'h0A0B0C, 2'd0);

    // Random frames against a byte-list model
    exp_q.delete();
    acc.delete();
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  d;
      logic        p, s;
      int          r;
      logic [23:0] pk;
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
      if (r == 0) p = ~p;
      s = (r == 1) ? 1'b0 : 1'b1;
      if (!s) begin
        exp_q.push_back({2'd2, 24'd0, 2'b10});
        acc.delete();
      end else if ((($countones(d) + int'(p)) % 2) == 0) begin
        exp_q.push_back({2'd2, 24'd0, 2'b01});
        acc.delete();
      end else begin
        acc.push_back(d);
        if (acc.size() == WORDS) begin
          pk = '0;
          for (int k = 0; k < WORDS; k++) pk = (pk << 8) | 24'(acc[k]);
          exp_q.push_back({2'd1, pk, 2'd0});
          acc.delete();
        end
      end
      send_frame(d, p, s);
      cyc($urandom_range(0, 30));
    end
    @(posedge ck);
    chk("rand event_count", 64'(ev_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("rand ev%0d", i), 64'(ev_q[i]), 64'(exp_q[i]));

    chk("pv_ev_overlap", 64'(n_both), 64'd0);
    chk("data_hold", 64'(n_spur), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
